// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port scheduler: calc1 command and
// response encodings, scheduler FSM states and a one-hot helper.
package calc1_pkg;

    localparam int CLI_N = 4;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_OVF_INV = 2'd2;
    localparam logic [1:0] RESP_ERR     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_OP2  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Client-indexed vectors are ascending, so client 0 is the leftmost bit.
    function automatic logic [0:CLI_N-1] id_onehot(input logic [1:0] id);
        logic [0:CLI_N-1] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/calc1_port_sched_if.sv
// Client-side bundle of the calc1 port scheduler: transaction request
// handshake plus the one-hot response strobe and shared response bus.
// Client-indexed vectors are ascending: client i owns bit i / slice i.
interface calc1_port_sched_if;

    logic [0:3]   cli_valid;
    logic [0:15]  cli_cmd;
    logic [0:127] cli_op1;
    logic [0:127] cli_op2;
    logic [0:3]   cli_ready;
    logic [0:3]   rsp_valid;
    logic [1:0]   rsp_resp;
    logic [31:0]  rsp_data;

    modport master (
        output cli_valid, cli_cmd, cli_op1, cli_op2,
        input  cli_ready, rsp_valid, rsp_resp, rsp_data
    );

    modport slave (
        input  cli_valid, cli_cmd, cli_op1, cli_op2,
        output cli_ready, rsp_valid, rsp_resp, rsp_data
    );

endinterface

// File: rtl/calc1_rr_arb.sv
// Four-way round-robin arbiter: combinational grant searching upward from
// a registered pointer; the pointer moves past the winner on acceptance.
module calc1_rr_arb (
    input  logic       c_clk,
    input  logic       reset,
    input  logic [0:3] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    logic [1:0] ptr;

    // First requester at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        gnt_valid = 1'b0;
        gnt_id    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    // Winner becomes lowest priority for the next round.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= gnt_id + 2'd1;
        end
    end

endmodule

// File: rtl/calc1_port_sched.sv
// Shares one calc1 request port between four clients. A granted client's
// transaction is serialised as cmd+op1 then op2, the calc1 response (or a
// timeout) is awaited and returned to that client as a one-cycle strobe.
//
//   state | meaning
//   IDLE  | no transaction; grant a valid client (cli_ready pulses)
//   CMD   | port drives captured cmd and operand1
//   OP2   | port drives operand2; early response accepted here
//   WAIT  | port idle; await non-zero response or timeout
//   DONE  | rsp_valid to owner; no new grant this cycle
module calc1_port_sched
    import calc1_pkg::*;
#(
    parameter int NCLI    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                c_clk,
    input  logic                reset,
    calc1_port_sched_if.slave   cli,
    output logic [3:0]          port_cmd,
    output logic [31:0]         port_data,
    input  logic [1:0]          port_resp,
    input  logic [31:0]         port_out_data,
    output logic                timeout_err,
    output logic                spurious_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  id_q;
    logic [31:0] op2_q;
    logic [7:0]  wait_cnt;

    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        accept;
    logic [3:0]  g_cmd;
    logic [31:0] g_op1;
    logic [31:0] g_op2;

    assign accept = (state == ST_IDLE) && gnt_valid;

    calc1_rr_arb u_arb (
        .c_clk     (c_clk),
        .reset     (reset),
        .req       (cli.cli_valid),
        .advance   (accept),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Select the granted client's transaction fields.
    always_comb begin
        g_cmd = '0;
        g_op1 = '0;
        g_op2 = '0;
        for (int i = 0; i < NCLI; i++) begin
            if (gnt_id == 2'(i)) begin
                g_cmd = cli.cli_cmd[4*i +: 4];
                g_op1 = cli.cli_op1[32*i +: 32];
                g_op2 = cli.cli_op2[32*i +: 32];
            end
        end
    end

    // Acceptance pulse is combinational so the client sees it in the grant cycle.
    always_comb begin
        cli.cli_ready = '0;
        if (accept) begin
            cli.cli_ready = id_onehot(gnt_id);
        end
    end

    // Transaction sequencer; all port and response outputs are registered.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            id_q          <= '0;
            op2_q         <= '0;
            wait_cnt      <= '0;
            port_cmd      <= '0;
            port_data     <= '0;
            cli.rsp_valid <= '0;
            cli.rsp_resp  <= RESP_NONE;
            cli.rsp_data  <= '0;
            timeout_err   <= 1'b0;
            spurious_err  <= 1'b0;
        end else begin
            cli.rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (port_resp != RESP_NONE) begin
                        spurious_err <= 1'b1;
                    end
                    if (gnt_valid) begin
                        id_q      <= gnt_id;
                        op2_q     <= g_op2;
                        port_cmd  <= g_cmd;
                        port_data <= g_op1;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (port_resp != RESP_NONE) begin
                        spurious_err <= 1'b1;
                    end
                    port_cmd  <= '0;
                    port_data <= op2_q;
                    state     <= ST_OP2;
                end
                ST_OP2: begin
                    port_data <= '0;
                    wait_cnt  <= '0;
                    if (port_resp != RESP_NONE) begin
                        cli.rsp_valid <= id_onehot(id_q);
                        cli.rsp_resp  <= port_resp;
                        cli.rsp_data  <= port_out_data;
                        state         <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A real response on the last waiting cycle beats the timeout.
                    if (port_resp != RESP_NONE) begin
                        cli.rsp_valid <= id_onehot(id_q);
                        cli.rsp_resp  <= port_resp;
                        cli.rsp_data  <= port_out_data;
                        state         <= ST_DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        cli.rsp_valid <= id_onehot(id_q);
                        cli.rsp_resp  <= RESP_ERR;
                        cli.rsp_data  <= '0;
                        timeout_err   <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
